// File: rtl/dyn_phase_pkg.sv
// Shared types and constants for the PLL dynamic-phase sequencer.
package dyn_phase_pkg;

  typedef logic [2:0] state_e;

  localparam state_e IDLE      = 3'd0;
  localparam state_e CHECK     = 3'd1;
  localparam state_e REQ       = 3'd2;
  localparam state_e WAIT_LOW  = 3'd3;
  localparam state_e WAIT_HIGH = 3'd4;
  localparam state_e GAP       = 3'd5;

  localparam logic [1:0] DYN_IDLE = 2'b00;
  localparam logic [1:0] DYN_UP   = 2'b01;
  localparam logic [1:0] DYN_DOWN = 2'b10;

  localparam logic [3:0] SEL_ALL = 4'd0;
  localparam logic [3:0] SEL_M   = 4'd1;
  localparam logic [3:0] SEL_C0  = 4'd2;
  localparam logic [3:0] SEL_C1  = 4'd3;
  localparam logic [3:0] SEL_C2  = 4'd4;
  localparam logic [3:0] SEL_C3  = 4'd5;
  localparam logic [3:0] SEL_C4  = 4'd6;

endpackage

// File: rtl/dyn_phase_ctrl_if.sv
// Command, readback and PLL state-machine signals of the dynamic-phase sequencer.
interface dyn_phase_ctrl_if #(
  parameter int unsigned STEP_W = 8
);
  logic              WR_EN;
  logic [3:0]        WR_SEL;
  logic [STEP_W-1:0] WR_TARGET;
  logic              ERR_CLR;
  logic [3:0]        RD_SEL;
  logic [STEP_W-1:0] RD_OFFSET;
  logic              PHASEDONE;
  logic [3:0]        COUNTER;
  logic [1:0]        DYN_PHASE;
  logic              BUSY;
  logic              DONE;
  logic              REJECT;
  logic              ERR;

  modport master (
    output WR_EN, WR_SEL, WR_TARGET, ERR_CLR, RD_SEL, PHASEDONE,
    input  RD_OFFSET, COUNTER, DYN_PHASE, BUSY, DONE, REJECT, ERR
  );

  modport slave (
    input  WR_EN, WR_SEL, WR_TARGET, ERR_CLR, RD_SEL, PHASEDONE,
    output RD_OFFSET, COUNTER, DYN_PHASE, BUSY, DONE, REJECT, ERR
  );
endinterface

// File: rtl/dyn_phase_sync.sv
// Two-flop synchroniser for PHASEDONE; resets high because the PLL idles with PHASEDONE high.
module dyn_phase_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/dyn_phase_ctrl.sv
// Steps one PLL counter select toward a signed target offset, one PHASEDONE handshake per step.
module dyn_phase_ctrl
  import dyn_phase_pkg::*;
#(
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned NUM_SEL = 7,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned GAP_CYC = 4
) (
  input logic             CLK50M,
  input logic             RESET,
  dyn_phase_ctrl_if.slave bus
);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);

  state_e            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [STEP_W-1:0] target_q, target_d;
  logic              up_q, up_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [STEP_W-1:0] off_q [NUM_SEL];
  logic [STEP_W-1:0] off_d [NUM_SEL];
  logic [3:0]        counter_q, counter_d;
  logic [1:0]        dyn_q, dyn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              reject_q, reject_d;
  logic              err_q, err_d;
  logic [STEP_W-1:0] rd_q, rd_d;
  logic [STEP_W-1:0] cur_off;
  logic              phasedone_s;
  logic              wr_ok;
  logic              timeout;

  dyn_phase_sync u_sync (
    .clk_i (CLK50M),
    .rst_i (RESET),
    .d_i   (bus.PHASEDONE),
    .q_o   (phasedone_s)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    target_d  = target_q;
    up_d      = up_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    counter_d = counter_q;
    dyn_d     = DYN_IDLE;
    done_d    = 1'b0;
    reject_d  = 1'b0;
    timeout   = 1'b0;
    cur_off   = '0;
    rd_d      = '0;
    for (int i = 0; i < int'(NUM_SEL); i++) begin
      off_d[i] = off_q[i];
      if (sel_q == 4'(i)) cur_off = off_q[i];
      if (bus.RD_SEL == 4'(i)) rd_d = off_q[i];
    end

    // busy_q still high in the IDLE cycle that carries DONE, so that cycle rejects too
    wr_ok = bus.WR_EN && (state_q == IDLE) && !busy_q && (32'(bus.WR_SEL) < NUM_SEL);
    if (bus.WR_EN && !wr_ok) reject_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          sel_d     = bus.WR_SEL;
          target_d  = bus.WR_TARGET;
          counter_d = bus.WR_SEL;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (target_q == cur_off) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          up_d    = $signed(target_q) > $signed(cur_off);
          dyn_d   = up_d ? DYN_UP : DYN_DOWN;
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!phasedone_s) begin
          tmo_d   = '0;
          state_d = WAIT_HIGH;
        end else if (tmo_q == TmoW'(TIMEOUT)) begin
          timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      WAIT_HIGH: begin
        if (phasedone_s) begin
          for (int i = 0; i < int'(NUM_SEL); i++) begin
            if (sel_q == 4'(i)) off_d[i] = up_q ? off_q[i] + STEP_W'(1) : off_q[i] - STEP_W'(1);
          end
          gap_d   = '0;
          state_d = GAP;
        end else if (tmo_q == TmoW'(TIMEOUT)) begin
          timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      GAP: begin
        if (gap_q == GapW'(GAP_CYC - 1)) state_d = CHECK;
        else gap_d = gap_q + GapW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (timeout) state_d = IDLE;

    err_d = err_q;
    if (bus.ERR_CLR) err_d = 1'b0;
    if (timeout) err_d = 1'b1;

    // BUSY lingers through the DONE cycle so it falls one cycle after DONE rises
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge CLK50M or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      target_q  <= '0;
      up_q      <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
      counter_q <= '0;
      dyn_q     <= DYN_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      reject_q  <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      for (int i = 0; i < int'(NUM_SEL); i++) off_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      target_q  <= target_d;
      up_q      <= up_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      counter_q <= counter_d;
      dyn_q     <= dyn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      reject_q  <= reject_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      for (int i = 0; i < int'(NUM_SEL); i++) off_q[i] <= off_d[i];
    end
  end

  assign bus.RD_OFFSET = rd_q;
  assign bus.COUNTER   = counter_q;
  assign bus.DYN_PHASE = dyn_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.REJECT    = reject_q;
  assign bus.ERR       = err_q;
endmodule
